// File: rtl/mips_16_boot_ctrl.sv
`timescale 1ns/1ps
// mips_16_boot_ctrl: loads a byte-stream image into instruction memory, then runs the core.
// Define MIPS_16_BOOT_CKSUM_EN to require a trailing 8-bit checksum byte before RUN.
module mips_16_boot_ctrl #(
    parameter int IMEM_AW = 8,
    parameter int IW      = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [IMEM_AW:0]   len,
    input  logic [CNT_W-1:0]   run_cycles,
    input  logic               s_valid,
    input  logic [7:0]         s_data,
    output logic               s_ready,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [IW-1:0]      imem_wdata,
    output logic               core_rst,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_HI,
        S_RX_LO,
        S_WR,
`ifdef MIPS_16_BOOT_CKSUM_EN
        S_CK,
`endif
        S_RUN,
        S_HALT,
        S_ERR
    } state_e;

    localparam logic [IMEM_AW-1:0] ADDR_ONE = {{(IMEM_AW-1){1'b0}}, 1'b1};
    localparam logic [IMEM_AW:0]   LEN_ONE  = {{IMEM_AW{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [IMEM_AW-1:0] addr_q, addr_d;
    logic [IMEM_AW:0]   len_q, len_d;
    logic [CNT_W-1:0]   rc_q, rc_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;
    logic [7:0]         hi_q, hi_d;
    logic [7:0]         lo_q, lo_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               last;
`ifdef MIPS_16_BOOT_CKSUM_EN
    logic [7:0]         sum_q, sum_d;
`endif

    assign imem_addr  = addr_q;
    assign imem_wdata = IW'({hi_q, lo_q});
    assign done       = done_q;
    assign err        = err_q;
    // Address counter stops at len-1, so a full-depth image never wraps.
    assign last       = ({1'b0, addr_q} == (len_q - LEN_ONE));

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        rc_d     = rc_q;
        cyc_d    = cyc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = done_q;
        err_d    = err_q;
`ifdef MIPS_16_BOOT_CKSUM_EN
        sum_d    = sum_q;
`endif
        s_ready  = 1'b0;
        imem_we  = 1'b0;
        core_rst = 1'b1;
        busy     = 1'b0;

        unique case (state_q)
            S_IDLE, S_HALT, S_ERR: begin
                if (start) begin
                    len_d  = len;
                    rc_d   = run_cycles;
                    done_d = 1'b0;
                    err_d  = 1'b0;
                    addr_d = '0;
                    cyc_d  = '0;
`ifdef MIPS_16_BOOT_CKSUM_EN
                    sum_d  = '0;
`endif
                    if (len == '0) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_RX_HI;
                    end
                end
            end
            S_RX_HI: begin
                busy    = 1'b1;
                s_ready = 1'b1;
                if (s_valid) begin
                    hi_d    = s_data;
`ifdef MIPS_16_BOOT_CKSUM_EN
                    sum_d   = sum_q + s_data;
`endif
                    state_d = S_RX_LO;
                end
            end
            S_RX_LO: begin
                busy    = 1'b1;
                s_ready = 1'b1;
                if (s_valid) begin
                    lo_d    = s_data;
`ifdef MIPS_16_BOOT_CKSUM_EN
                    sum_d   = sum_q + s_data;
`endif
                    state_d = S_WR;
                end
            end
            S_WR: begin
                busy    = 1'b1;
                imem_we = 1'b1;
                if (last) begin
                    cyc_d   = '0;
`ifdef MIPS_16_BOOT_CKSUM_EN
                    state_d = S_CK;
`else
                    state_d = S_RUN;
`endif
                end else begin
                    addr_d  = addr_q + ADDR_ONE;
                    state_d = S_RX_HI;
                end
            end
`ifdef MIPS_16_BOOT_CKSUM_EN
            S_CK: begin
                busy    = 1'b1;
                s_ready = 1'b1;
                if (s_valid) begin
                    if ((sum_q + s_data) == 8'h00) begin
                        cyc_d   = '0;
                        state_d = S_RUN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
`endif
            S_RUN: begin
                busy     = 1'b1;
                core_rst = 1'b0;
                cyc_d    = cyc_q + CNT_ONE;
                if ((rc_q != '0) && (cyc_q == (rc_q - CNT_ONE))) begin
                    done_d  = 1'b1;
                    state_d = S_HALT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything, including a same-cycle start.
        if (abort) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            err_d   = 1'b0;
            addr_d  = '0;
            cyc_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            rc_q    <= '0;
            cyc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef MIPS_16_BOOT_CKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            rc_q    <= rc_d;
            cyc_q   <= cyc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef MIPS_16_BOOT_CKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

endmodule

// File: doc/mips_16_boot_ctrl.md
MIPS_16_BOOT_CTRL -- requirements
Module: mips_16_boot_ctrl

Interface
REQ-001 Parameter IMEM_AW, default 8, instruction-memory address width (matches PC width).
REQ-002 Parameter IW, default 16, instruction width.
REQ-003 Parameter CNT_W, default 16, run-cycle counter width.
REQ-004 clk  in  1  single system clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  begin load-and-run sequence (single-cycle pulse).
REQ-007 abort  in  1  return to IDLE from any state.
REQ-008 len  in  IMEM_AW+1  instruction count to load, legal 1..2^IMEM_AW.
REQ-009 run_cycles  in  CNT_W  core run budget in cycles; 0 = unlimited.
REQ-010 s_valid  in  1  byte-stream data valid.
REQ-011 s_data  in  8  byte-stream data.
REQ-012 s_ready  out  1  byte accepted when s_valid && s_ready.
REQ-013 imem_we  out  1  instruction-memory write strobe.
REQ-014 imem_addr  out  IMEM_AW  write address.
REQ-015 imem_wdata  out  IW  write data.
REQ-016 core_rst  out  1  active-high reset to core.
REQ-017 busy / done / err  out  1 each  status flags.

Function
REQ-018 States SHALL be IDLE, RX_HI, RX_LO, WR, CK (CKSUM only), RUN, HALT, ERR.
REQ-019 In IDLE, HALT, ERR: core_rst=1, s_ready=0, imem_we=0; start latches len and run_cycles and clears done/err.
REQ-020 start with len==0 SHALL go to ERR; otherwise RX_HI with address counter=0.
REQ-021 RX_HI/RX_LO: s_ready=1; accepted byte captured as bits [15:8] then [7:0]; no transfer = hold state.
REQ-022 WR: exactly one cycle, s_ready=0, imem_we=1, imem_addr=counter, imem_wdata={hi,lo}.
REQ-023 After WR: counter==len-1 -> CK (if enabled) else RUN; otherwise counter+1 -> RX_HI; no address wrap.
REQ-024 RUN: core_rst=0, cycle counter starts at 0 on entry, increments each cycle.
REQ-025 run_cycles!=0: after exactly run_cycles RUN cycles -> HALT, core_rst=1, done=1.
REQ-026 run_cycles==0: stay in RUN until abort.
REQ-027 busy=1 in RX_HI, RX_LO, WR, CK, RUN; else 0.
REQ-028 done and err sticky until next accepted start or abort.
REQ-029 abort in any state -> IDLE next cycle, core_rst=1, flags cleared; abort with start same cycle: abort wins.
REQ-030 start outside IDLE/HALT/ERR SHALL be ignored.
REQ-031 Image at len=2^IMEM_AW SHALL write addresses 0..2^IMEM_AW-1.

Reset
REQ-032 rst low asynchronously forces IDLE: core_rst=1, s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, counters 0.
REQ-033 rst mid-load or mid-run abandons sequence; no further imem writes until new start.

Configuration
REQ-034 Macro MIPS_16_BOOT_CKSUM_EN defined: after last WR enter CK, s_ready=1, accept one byte; 8-bit sum of all image bytes plus it ==0 -> RUN, else ERR (err=1, core held in reset).
REQ-035 Macro undefined: no CK state, no checksum logic, last WR goes directly to RUN.

Verification
REQ-036 rst low, release -> core_rst=1, all other outputs 0, state IDLE.
REQ-037 start, len=3, bytes 12 34 56 78 9A BC, run_cycles=10 -> writes 0:1234, 1:5678, 2:9ABC; core_rst low exactly 10 cycles; done=1.
REQ-038 s_valid toggling every other cycle during load -> same memory contents, no duplicate or lost writes.
REQ-039 start with len=0 -> err=1, no imem_we, core_rst stays 1.
REQ-040 abort asserted in RUN with run_cycles=0 -> IDLE next cycle, core_rst=1, done=0.
REQ-041 CKSUM_EN: len=1, bytes 01 02 then FD -> RUN; repeat with FC -> ERR, err=1.
